// File: rtl/sram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : sram_burst_master
//  Description : Burst initiator for the SRAM controller user port. Accepts
//                one burst command at a time and issues one access per cycle
//                at consecutive 20-bit word addresses (wrapping modulo 2^20).
//                Write bursts stream words in on wr_data/wr_valid/wr_ready.
//                Read bursts stream words out on rd_data/rd_valid.
//                A tag shift register follows each read through the fixed
//                SRAM latency, so every returned word is flagged valid once.
//
//  Ports       : Clock_50        - system clock
//                Reset           - synchronous active-high reset
//                SRAM_ready      - controller ready; no access issued when low
//                SRAM_read_data  - controller read data (READ_LATENCY after addr)
//                cmd_valid/ready - burst command handshake
//                cmd_write       - 1 = write burst, 0 = read burst
//                cmd_addr        - burst start word address
//                cmd_len         - burst length in words (0 = no-op)
//                wr_data/valid/ready - write word stream
//                rd_data/rd_valid    - read word stream (no backpressure)
//                busy            - high whenever not IDLE
//                done            - one-cycle pulse at end of burst
//                SRAM_address/SRAM_write_data/SRAM_we_n - registered to controller
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_burst_master #(
    parameter int READ_LATENCY = 2,
    parameter int LEN_W        = 16
) (
    input  logic             Clock_50,
    input  logic             Reset,
    input  logic             SRAM_ready,
    input  logic [15:0]      SRAM_read_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [19:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [15:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic [19:0]      SRAM_address,
    output logic [15:0]      SRAM_write_data,
    output logic             SRAM_we_n
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_READ  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    // Tag bit k is set while the read address presented k cycles ago is
    // in flight; bit READ_LATENCY lines up with its data on SRAM_read_data.
    localparam int c_TAG_W = READ_LATENCY + 1;

    logic [1:0]         r_state;
    logic [19:0]        r_addr;
    logic [LEN_W-1:0]   r_remaining;
    logic [c_TAG_W-1:0] r_tag;

    logic w_cmd_fire;
    logic w_wr_fire;
    logic w_last_word;
    logic w_tag_push;
    logic w_last_tag;

    // done is high for the single IDLE cycle that ends a burst; holding
    // cmd_ready low then keeps a new command out of that cycle.
    assign cmd_ready   = (r_state == c_ST_IDLE) && !done;
    assign wr_ready    = (r_state == c_ST_WRITE) && SRAM_ready;
    assign busy        = (r_state != c_ST_IDLE);

    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_wr_fire   = wr_valid && wr_ready;
    assign w_last_word = (r_remaining == LEN_W'(1));
    assign w_tag_push  = (r_state == c_ST_READ) && SRAM_ready;

    // In DRAIN only zeros are shifted in, so the final word's tag is the one
    // reaching the output stage with nothing younger behind it.
    assign w_last_tag  = (r_state == c_ST_DRAIN) && r_tag[READ_LATENCY]
                         && (r_tag[READ_LATENCY-1:0] == '0);

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_state         <= c_ST_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_tag           <= '0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            rd_data         <= '0;
            rd_valid        <= 1'b0;
            done            <= 1'b0;
        end else begin
            done      <= 1'b0;
            SRAM_we_n <= 1'b1;
            r_tag     <= {r_tag[c_TAG_W-2:0], w_tag_push};

            // Capture read data at the end of the cycle it is presented.
            rd_valid  <= r_tag[READ_LATENCY];
            if (r_tag[READ_LATENCY]) begin
                rd_data <= SRAM_read_data;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_addr      <= cmd_addr;
                        r_remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else if (cmd_write) begin
                            r_state <= c_ST_WRITE;
                        end else begin
                            r_state <= c_ST_READ;
                        end
                    end
                end

                c_ST_WRITE: begin
                    if (w_wr_fire) begin
                        SRAM_address    <= r_addr;
                        SRAM_write_data <= wr_data;
                        SRAM_we_n       <= 1'b0;
                        r_addr          <= r_addr + 20'd1;
                        r_remaining     <= r_remaining - LEN_W'(1);
                        if (w_last_word) begin
                            r_state <= c_ST_IDLE;
                            done    <= 1'b1;
                        end
                    end
                end

                c_ST_READ: begin
                    if (SRAM_ready) begin
                        SRAM_address <= r_addr;
                        r_addr       <= r_addr + 20'd1;
                        r_remaining  <= r_remaining - LEN_W'(1);
                        if (w_last_word) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end

                c_ST_DRAIN: begin
                    if (w_last_tag) begin
                        r_state <= c_ST_IDLE;
                        done    <= 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_burst_master
//  Description : Scoreboard bench for sram_burst_master. Expected SRAM writes,
//                read words and done events are queued when a command is
//                issued; a monitor pops and compares as the DUT presents them.
//                A 2-cycle SRAM model answers the DUT's reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_burst_master;

    logic        Clock_50 = 1'b0;
    logic        Reset;
    logic        SRAM_ready;
    logic [15:0] SRAM_read_data = 16'h0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [19:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [19:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    sram_burst_master #(.READ_LATENCY(2), .LEN_W(16)) dut (
        .Clock_50       (Clock_50),
        .Reset          (Reset),
        .SRAM_ready     (SRAM_ready),
        .SRAM_read_data (SRAM_read_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .busy           (busy),
        .done           (done),
        .SRAM_address   (SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n      (SRAM_we_n)
    );

    initial forever #5 Clock_50 = ~Clock_50;

    int cyc = 0;
    always @(posedge Clock_50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [35:0] wq[$];     // {address, data} of expected SRAM writes
    logic [15:0] rq[$];     // expected read words, in order
    int          dq[$];     // expected done: 0 no-op, 1 write, 2 read

    logic [15:0] ref_mem  [logic [19:0]];
    logic [15:0] sram_mem [logic [19:0]];
    logic [19:0] sram_p1 = 20'h0;

    int  force_low    = 0;
    bit  stall_en     = 1'b0;
    bit  mon_en       = 1'b0;
    int  first_rd_cyc = -1;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // SRAM model: write on we_n low, read data appears 2 cycles after address.
    always @(posedge Clock_50) begin
        if (!SRAM_we_n) sram_mem[SRAM_address] = SRAM_write_data;
    end
    always @(posedge Clock_50) begin
        sram_p1        <= SRAM_address;
        SRAM_read_data <= sram_mem.exists(sram_p1) ? sram_mem[sram_p1] : 16'h0;
    end

    // Controller readiness: forced stalls, random stalls, or always ready.
    initial begin
        SRAM_ready = 1'b1;
        forever begin
            @(posedge Clock_50);
            #1;
            if (force_low > 0) begin
                SRAM_ready = 1'b0;
                force_low--;
            end else if (stall_en) begin
                SRAM_ready = ($urandom_range(0, 3) != 0);
            end else begin
                SRAM_ready = 1'b1;
            end
        end
    end

    // Monitor
    logic [35:0] m_w;
    logic [15:0] m_r;
    int          m_kind;
    initial forever begin
        @(negedge Clock_50);
        if (mon_en) begin
            if (!SRAM_we_n) begin
                check(wq.size() != 0, "wr_unexpected", 64'(SRAM_address), 64'(0));
                if (wq.size() != 0) begin
                    m_w = wq.pop_front();
                    check({SRAM_address, SRAM_write_data} == m_w, "wr_access",
                          64'({SRAM_address, SRAM_write_data}), 64'(m_w));
                end
            end
            if (rd_valid) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                check(rq.size() != 0, "rd_unexpected", 64'(rd_data), 64'(0));
                if (rq.size() != 0) begin
                    m_r = rq.pop_front();
                    check(rd_data == m_r, "rd_data", 64'(rd_data), 64'(m_r));
                end
            end
            if (done) begin
                check(dq.size() != 0, "done_unexpected", 64'(1), 64'(0));
                if (dq.size() != 0) begin
                    m_kind = dq.pop_front();
                    check(wq.size() == 0 && rq.size() == 0, "done_early",
                          64'(wq.size() + rq.size()), 64'(0));
                    check(!cmd_ready, "cmd_ready_on_done", 64'(cmd_ready), 64'(0));
                    if (m_kind == 1) check(!SRAM_we_n, "done_with_last_write", 64'(SRAM_we_n), 64'(0));
                    if (m_kind == 2) check(rd_valid, "done_with_last_read", 64'(rd_valid), 64'(1));
                end
            end
        end
    end

    // Issue one burst, queue its expected effects, wait for done.
    // vmode: 0 wr_valid held high, 1 toggling, 2 random.
    // dbase >= 0 gives data dbase+i; otherwise random data.
    task automatic run_cmd(input bit wr, input logic [19:0] a, input int n,
                           input int vmode, input int dbase,
                           input int stall_at, input int exp_lat);
        logic [15:0] d[$];
        logic [19:0] aa;
        int c, idx, k, t, done_cyc;
        bit got;
        for (int i = 0; i < n; i++) begin
            aa = a + 20'(i);
            if (wr) begin
                d.push_back((dbase >= 0) ? 16'(dbase + i) : 16'($urandom));
                ref_mem[aa] = d[i];
                wq.push_back({aa, d[i]});
            end else begin
                rq.push_back(ref_mem.exists(aa) ? ref_mem[aa] : 16'h0);
            end
        end
        dq.push_back((n == 0) ? 0 : (wr ? 1 : 2));

        t = 0;
        @(negedge Clock_50);
        while (!cmd_ready && t < 50) begin
            @(negedge Clock_50);
            t++;
        end
        check(cmd_ready == 1'b1, "cmd_ready_timeout", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = 16'(n);
        c = cyc;
        first_rd_cyc = -1;
        @(negedge Clock_50);
        cmd_valid = 1'b0;
        cmd_addr  = 20'($urandom);
        cmd_len   = 16'($urandom);

        idx = 0; k = 0; got = 1'b0; done_cyc = -1;
        while (!got && k < 300) begin
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
            end else begin
                if (k == stall_at) force_low = 2;
                if (wr && idx < n) begin
                    if (vmode == 0)      wr_valid = 1'b1;
                    else if (vmode == 1) wr_valid = (k % 2 == 0);
                    else                 wr_valid = ($urandom_range(0, 2) != 0);
                    wr_data = wr_valid ? d[idx] : 16'($urandom);
                    if (wr_valid && wr_ready) idx++;
                end else begin
                    wr_valid = 1'b0;
                end
                k++;
                @(negedge Clock_50);
            end
        end
        wr_valid = 1'b0;
        check(got, "done_timeout", 64'(k), 64'(n));
        if (exp_lat >= 0)
            check(done_cyc - c == exp_lat, "done_latency", 64'(done_cyc - c), 64'(exp_lat));
        @(negedge Clock_50);
        check(cmd_ready == 1'b1, "cmd_ready_after_done", 64'(cmd_ready), 64'(1));
        if (exp_lat >= 0 && !wr && n > 0)
            check(first_rd_cyc - c == 5, "first_rd_latency", 64'(first_rd_cyc - c), 64'(5));
    endtask

    task automatic check_reset_values();
        check(SRAM_address == 20'h0,    "rst_address",    64'(SRAM_address),    64'(0));
        check(SRAM_write_data == 16'h0, "rst_write_data", 64'(SRAM_write_data), 64'(0));
        check(SRAM_we_n == 1'b1,        "rst_we_n",       64'(SRAM_we_n),       64'(1));
        check(rd_data == 16'h0,         "rst_rd_data",    64'(rd_data),         64'(0));
        check(rd_valid == 1'b0,         "rst_rd_valid",   64'(rd_valid),        64'(0));
        check(done == 1'b0,             "rst_done",       64'(done),            64'(0));
        check(busy == 1'b0,             "rst_busy",       64'(busy),            64'(0));
        check(cmd_ready == 1'b1,        "rst_cmd_ready",  64'(cmd_ready),       64'(1));
    endtask

    initial begin
        Reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 20'h0;
        cmd_len = 16'h0; wr_data = 16'h0; wr_valid = 1'b0;
        repeat (3) @(posedge Clock_50);
        @(negedge Clock_50);
        check_reset_values();
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Directed bursts with exact timing expectations.
        run_cmd(1'b1, 20'h00100, 4, 0, 16'hA000, -1, 5);
        run_cmd(1'b0, 20'h00100, 4, 0, -1, -1, 8);
        run_cmd(1'b1, 20'h00200, 3, 1, -1, -1, 6);
        run_cmd(1'b1, 20'hFFFFE, 4, 0, -1, -1, 5);
        run_cmd(1'b0, 20'hFFFFE, 4, 0, -1, -1, 8);
        run_cmd(1'b1, 20'h00300, 8, 0, -1, -1, 9);
        run_cmd(1'b0, 20'h00300, 8, 0, -1, 2, 14);
        run_cmd(1'b0, 20'h00100, 1, 0, -1, -1, 5);

        // Reset in the middle of a read with two words in flight.
        @(negedge Clock_50);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00100; cmd_len = 16'd8;
        @(negedge Clock_50);
        cmd_valid = 1'b0;
        @(negedge Clock_50);
        @(negedge Clock_50);
        check(busy == 1'b1, "busy_mid_read", 64'(busy), 64'(1));
        Reset = 1'b1;
        @(negedge Clock_50);
        check_reset_values();
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock_50);
            check(!rd_valid && !done, "stale_after_reset",
                  64'({rd_valid, done}), 64'(0));
        end
        run_cmd(1'b0, 20'h00123, 0, 0, -1, -1, 1);

        // Randomized bursts with random stalls on both streams.
        for (int j = 0; j < 24; j++) begin
            logic [19:0] ra;
            stall_en = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) ra = 20'hFFFFA + 20'($urandom_range(0, 5));
            else                           ra = 20'h00100 + 20'($urandom_range(0, 40));
            run_cmd($urandom_range(0, 1) == 1, ra, $urandom_range(0, 10), 2, -1, -1, -1);
        end
        stall_en = 1'b0;
        repeat (6) @(negedge Clock_50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sram_burst_master.md
Name: sram_burst_master

Overview:
- Client-side initiator for the SRAM controller's user port (address / write data / we_n in, read data out, fixed 2-cycle read latency).
- Accepts one burst command at a time, either a write of N words streamed in or a read of N words streamed out.
- Issues one SRAM access per cycle at consecutive addresses.
- Tracks the read pipeline so returned words are tagged valid exactly once.
- Sits between datapath stages (colour-space / IDCT engines) and the SRAM controller.

Parameters:
- READ_LATENCY, 2, cycles from a read address on SRAM_address to its data on SRAM_read_data.
- LEN_W, 16, width of the burst length field.

Ports:
- Clock_50  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- SRAM_ready  in  1  controller ready; no access is issued while low.
- cmd_valid  in  1  burst command present.
- cmd_ready  out  1  high in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  20  burst start word address.
- cmd_len  in  LEN_W  number of words; 0 = no-op.
- wr_data  in  16  write stream data.
- wr_valid  in  1  write word present.
- wr_ready  out  1  write word taken this cycle when wr_valid && wr_ready.
- rd_data  out  16  read stream data.
- rd_valid  out  1  rd_data valid this cycle. No backpressure.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse at end of burst.
- SRAM_address  out  20  to controller, registered.
- SRAM_write_data  out  16  to controller, registered.
- SRAM_we_n  out  1  to controller, registered, active-low write.

Behaviour:
- Reset (synchronous, Reset=1 at a Clock_50 edge):
  - State goes to IDLE and the read-tag shift register clears.
  - SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1.
  - rd_data=0, rd_valid=0, done=0, busy=0.
  - Reset mid-burst abandons the burst. In-flight read data is discarded (never flagged valid) and no done pulse is produced.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1, wr_ready=0, SRAM_we_n=1.
  - On accept, latch addr into an internal counter and len into a remaining-words counter.
  - len=0: stay IDLE; done=1 the next cycle.
  - cmd_write=1: go to WRITE. cmd_write=0: go to READ.
- WRITE:
  - wr_ready = SRAM_ready.
  - Each accepted word registers SRAM_address=addr, SRAM_write_data=wr_data, SRAM_we_n=0 for exactly one cycle. addr then increments and remaining decrements.
  - Cycles with no accepted word drive SRAM_we_n=1 and hold SRAM_address.
  - After the last word is accepted, go to IDLE; done=1 in the cycle its we_n=0 is presented.
- READ:
  - While SRAM_ready=1, register SRAM_address=addr, SRAM_we_n=1, and push a 1 into the READ_LATENCY+1-deep tag shift register; addr increments and remaining decrements.
  - While SRAM_ready=0, push 0 and hold the address.
  - After the last address is issued, go to DRAIN.
- Read timing:
  - An address presented in cycle t yields SRAM_read_data in cycle t+READ_LATENCY.
  - The block captures it at the end of that cycle and presents rd_data with rd_valid=1 in cycle t+READ_LATENCY+1.
  - Read throughput is one word per cycle.
- DRAIN:
  - Keep shifting the tag register, pushing 0.
  - When the tag of the last word emerges (rd_valid=1 for it), done=1 in the same cycle and go to IDLE. Burst-to-done for a read of N words with no stalls is N+READ_LATENCY+1 cycles after the first issue.
- Address arithmetic: 20-bit, wraps modulo 2^20 (0xFFFFF+1 → 0x00000), no error flag.
- Simultaneous events: cmd_valid is ignored outside IDLE. A command in the same cycle as done is not accepted; cmd_ready rises the cycle after done.
- rd_valid may still be high in the first IDLE cycle only when READ_LATENCY tags are pending. By construction DRAIN waits for all tags, so the next command always starts with an empty pipeline.
- Only write bursts stall on wr_valid. Both burst types stall on SRAM_ready.

Test Plan:
- Write burst addr=0x00100, len=4, wr_valid held high, data 0xA000..0xA003 → four consecutive cycles with we_n=0 at 0x00100..0x00103 carrying matching data; done on the fourth; cmd_ready high next cycle.
- Read burst addr=0x00100, len=4 against a 2-cycle SRAM model preloaded with the above → rd_valid high for 4 consecutive cycles, starting 3 cycles after the first address, with data 0xA000..0xA003; done coincides with the last rd_valid.
- Write burst len=3 with wr_valid toggling 1,0,1,0,1 → exactly 3 we_n=0 cycles at consecutive addresses; we_n=1 during gaps; address held.
- Read at addr=0xFFFFE, len=4 → addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001; four rd_valid pulses in order.
- Read burst len=8 with SRAM_ready low for 2 cycles mid-burst → 8 rd_valid pulses total with a 2-cycle gap; no duplicated or lost words.
- Reset=1 for one cycle during READ with 2 words in flight → all outputs at reset values next cycle; rd_valid never rises for the in-flight words; no done; cmd_valid with len=0 afterwards gives done one cycle later.
